// File: rtl/serial_pkg.sv
// Shared definitions for the serial bit source and the FSM_lab test environment.
package serial_pkg;

  // Default word width, shared with the sequence detector environment.
  localparam int SER_WIDTH = 20;

  // Serializer states.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ser_state_t;

endpackage : serial_pkg

// File: rtl/serial_bit_source.sv
// Parallel-to-serial source: takes a word over valid/ready and emits it
// MSB-first, one bit per enabled clock, feeding the FSM_lab detector input.
module serial_bit_source
  import serial_pkg::*;
#(
  parameter int   WIDTH      = SER_WIDTH,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  ser_state_t       state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic             last;
  logic             accept;

  // The final bit retires on an enabled edge; the next word may be taken on that same edge.
  always_comb begin
    last       = (state == ST_SHIFT) && en && (cnt == CNT_LAST);
    load_ready = (state == ST_IDLE) || last;
    accept     = load_valid && load_ready;
  end

  // Single FSM: loads, shifts, stalls and retires words; all outputs are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      sreg      <= '0;
      cnt       <= '0;
      ser_out   <= IDLE_LEVEL;
      ser_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            sreg      <= load_data;
            cnt       <= '0;
            state     <= ST_SHIFT;
            ser_out   <= load_data[WIDTH-1];
            ser_valid <= 1'b1;
            busy      <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (en) begin
            if (last) begin
              done <= 1'b1;
              if (accept) begin
                sreg    <= load_data;
                cnt     <= '0;
                ser_out <= load_data[WIDTH-1];
              end else begin
                state     <= ST_IDLE;
                sreg      <= '0;
                cnt       <= '0;
                ser_out   <= IDLE_LEVEL;
                ser_valid <= 1'b0;
                busy      <= 1'b0;
              end
            end else begin
              sreg    <= {sreg[WIDTH-2:0], 1'b0};
              cnt     <= cnt + 1'b1;
              ser_out <= sreg[WIDTH-2];
            end
          end
        end
        default: begin
          state     <= ST_IDLE;
          sreg      <= '0;
          cnt       <= '0;
          ser_out   <= IDLE_LEVEL;
          ser_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule : serial_bit_source

// File: tb/tb_serial_bit_source.sv
// Bench for serial_bit_source: directed scenarios followed by a randomized run,
// each cycle compared against a bit-queue model of the serial stream.
module tb_serial_bit_source;

  localparam int W = 20;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] load_data;
  logic         load_valid;
  logic         load_ready;
  logic         en;
  logic         ser_out;
  logic         ser_valid;
  logic         busy;
  logic         done;

  int compared   = 0;
  int mismatched = 0;

  // Model: bits still to appear on the line, front = bit currently shown.
  logic model_q[$];
  logic model_done;
  logic last_accepted;

  serial_bit_source #(.WIDTH(W), .IDLE_LEVEL(1'b0)) dut (
    .clk(clk),
    .rst(rst),
    .load_data(load_data),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .en(en),
    .ser_out(ser_out),
    .ser_valid(ser_valid),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic model_ready(input logic e);
    return (model_q.size() == 0) || (e && model_q.size() == 1);
  endfunction

  task automatic checkOutput(input string tag, input logic observed, input logic expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $display("[TB] FAIL %s observed=%b expected=%b at t=%0t", tag, observed, expected, $time);
      $error("[TB] assertion on %s", tag);
    end
  endtask

  task automatic checkRegistered();
    checkOutput("ser_valid", ser_valid, model_q.size() != 0);
    checkOutput("busy", busy, model_q.size() != 0);
    checkOutput("ser_out", ser_out, (model_q.size() != 0) ? model_q[0] : 1'b0);
    checkOutput("done", done, model_done);
  endtask

  // One clock: drive inputs, check the combinational ready, clock, update model, check outputs.
  task automatic applyStimulus(input logic v, input logic [W-1:0] d, input logic e);
    logic rdy;
    rst        = 1'b0;
    load_valid = v;
    load_data  = d;
    en         = e;
    #1;
    rdy = model_ready(e);
    checkOutput("load_ready", load_ready, rdy);
    @(posedge clk);
    model_done = 1'b0;
    if (model_q.size() != 0 && e) begin
      void'(model_q.pop_front());
      if (model_q.size() == 0) model_done = 1'b1;
    end
    last_accepted = v && rdy;
    if (last_accepted)
      for (int i = W - 1; i >= 0; i--) model_q.push_back(d[i]);
    #1;
    checkRegistered();
  endtask

  task automatic doReset(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      rst        = 1'b1;
      load_valid = 1'b1;
      load_data  = W'($urandom);
      en         = 1'b1;
      @(posedge clk);
      model_q.delete();
      model_done = 1'b0;
      #1;
      checkRegistered();
    end
    rst = 1'b0;
  endtask

  // Hold a word with valid high until it is taken; an expired bound is a failure.
  task automatic offerWord(input logic [W-1:0] d);
    int guard = 0;
    last_accepted = 1'b0;
    while (!last_accepted && guard < 100) begin
      applyStimulus(1'b1, d, 1'b1);
      guard++;
    end
    if (!last_accepted) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL accept_timeout observed=not_accepted expected=accepted word=%h", d);
    end
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, W'($urandom), 1'b1);
  endtask

  initial begin
    logic         pend_valid;
    logic [W-1:0] pend_data;
    logic         e;

    rst = 1'b1; load_valid = 1'b0; load_data = '0; en = 1'b0;
    model_done = 1'b0; last_accepted = 1'b0;
    @(negedge clk);

    $display("[TB] reset");
    doReset(2);
    idleCycles(2);

    $display("[TB] single word");
    offerWord(20'b0101_1110_0110_0111_1111);
    idleCycles(23);

    $display("[TB] back-to-back");
    offerWord(20'hFFFFF);
    offerWord(20'h00000);
    idleCycles(22);

    $display("[TB] stall");
    offerWord(20'h80001);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b0);
    idleCycles(22);

    $display("[TB] busy rejection");
    offerWord(20'hAAAAA);
    idleCycles(4);
    offerWord(20'h55555);
    idleCycles(22);

    $display("[TB] reset mid-word");
    offerWord(20'h5E67F);
    idleCycles(9);
    doReset(1);
    idleCycles(1);
    offerWord(20'h3C5A9);
    idleCycles(22);

    $display("[TB] randomized run");
    pend_valid = 1'b0;
    pend_data  = '0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        doReset(1);
        pend_valid = 1'b0;
      end else begin
        if (!pend_valid && $urandom_range(0, 2) != 0) begin
          pend_valid = 1'b1;
          pend_data  = W'($urandom);
        end
        e = ($urandom_range(0, 3) != 0);
        applyStimulus(pend_valid, pend_valid ? pend_data : W'($urandom), e);
        if (last_accepted) pend_valid = 1'b0;
      end
    end
    idleCycles(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_serial_bit_source

// File: doc/serial_bit_source.md
Name: serial_bit_source

Overview:
- Parallel-to-serial stage directly upstream of the FSM_lab sequence detector.
- Accepts a WIDTH-bit word over a valid/ready handshake and emits it MSB-first, one bit per clock, on ser_out, which drives the detector's in port.
- Supports back-to-back words with no idle gap, plus a stall input.
- Replaces ad-hoc bit-indexing stimulus with a synthesizable, reusable source.

Parameters:
- WIDTH, 20, bits per word; legal range WIDTH >= 2.
- IDLE_LEVEL, 1'b0, value driven on ser_out when no word is active.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- load_data  in  WIDTH  word to serialize; sampled only on an accepting edge.
- load_valid  in  1  upstream has a word on load_data.
- load_ready  out  1  block can accept a word this cycle (combinational).
- en  in  1  shift enable; 0 stalls emission and holds the current bit.
- ser_out  out  1  serial bit (registered); connects to FSM_lab in.
- ser_valid  out  1  (registered) ser_out carries a word bit.
- busy  out  1  (registered) state == SHIFT.
- done  out  1  (registered) one-cycle pulse after a word's last bit retires.

Behaviour:
- Reset values, taking effect at the first posedge with rst=1:
  - state=IDLE, shift register=0, cnt=0.
  - ser_out=IDLE_LEVEL, ser_valid=0, busy=0, done=0.
  - load_ready=1 the cycle after reset releases.
- rst has priority over every other input, including mid-word. A word in flight is dropped with no done pulse.
- Internal state:
  - sreg[WIDTH-1:0]; ser_out is always sreg[WIDTH-1] while in SHIFT.
  - cnt, width $clog2(WIDTH), counts bits already retired from the current word.
- States: IDLE, SHIFT.
- Retire condition: last = (state==SHIFT) && en && (cnt==WIDTH-1).
- load_ready = (state==IDLE) || last.
- Accept occurs at a posedge when load_valid && load_ready.
- IDLE:
  - On accept: sreg<=load_data, cnt<=0, state<=SHIFT, ser_valid<=1, busy<=1.
  - Latency is 1 cycle: the MSB appears on ser_out the cycle after the accepting edge.
  - With no accept, outputs hold their idle values.
- SHIFT with en=1 and not last: sreg<=sreg<<1 (LSB filled with 0), cnt<=cnt+1.
- SHIFT with en=0: sreg, cnt and all outputs hold. The current bit stays on ser_out and ser_valid stays 1.
- last without accept:
  - state<=IDLE, ser_valid<=0, busy<=0, ser_out<=IDLE_LEVEL.
  - done<=1 for exactly one cycle.
- last with accept (back-to-back):
  - sreg<=load_data, cnt<=0, stay in SHIFT.
  - done<=1 for one cycle while ser_valid stays 1.
  - The new MSB follows the old LSB with zero gap.
- Bit mapping: at the k-th enabled shifting cycle after accept (k=1..WIDTH), ser_out = word[WIDTH-k].
- load_valid while load_ready=0: ignored and nothing captured. Upstream must hold load_valid and load_data until accepted.
- load_data changing while not accepting has no effect.
- cnt never exceeds WIDTH-1. Wrap-around occurs only via the last transition, and is correct when WIDTH is not a power of 2.
- Unreachable state encodings recover to IDLE.

Decomposition:
- Shared package/header serial_pkg:
  - State encodings ST_IDLE=1'b0 and ST_SHIFT=1'b1.
  - Default WIDTH constant, shared with the FSM_lab test environment.
- No sub-module. The counter and shifter are small enough to stay inline in one module.

Test Plan:
- Single word: reset, then load 20'b0101_1110_0110_0111_1111 with en=1. Required response:
  - ser_out = 0,1,0,1,1,1,1,0,0,1,1,0,0,1,1,1,1,1,1,1 on cycles 1..20 after accept.
  - ser_valid high for exactly 20 cycles.
  - done pulses in cycle 21, and ser_out=0 from then on.
- Back-to-back: 20'hFFFFF then 20'h00000, with load_valid held. Required response:
  - Second word accepted on the edge retiring bit 20 of the first.
  - 20 ones then 20 zeros with no gap.
  - ser_valid continuously 1 for 40 cycles; done pulses at cycles 21 and 41.
- Stall: load 20'h80001 and drop en for 3 cycles after bit 1. Required response:
  - Bit 1 (=1) held for 4 cycles; the sequence then resumes with bit 2 (=0).
  - Total ser_valid length is 23 cycles; done pulses once.
- Busy rejection: load 20'hAAAAA, then assert load_valid with 20'h55555 at bit 5. Required response:
  - load_ready=0 until the bit-20 edge.
  - The full 20'hAAAAA stream is unaltered.
  - 20'h55555 is accepted at retirement and emitted next.
- Reset mid-word: assert rst for 1 cycle at bit 10 of 20'h5E67F. Required response:
  - Next cycle ser_out=0, ser_valid=0, busy=0, done=0, load_ready=1 after release.
  - A fresh load then serializes correctly from its MSB.
- System: drive FSM_lab.in from ser_out with the word from the single-word test. FSM out must match the golden model bit-for-bit over the 20 cycles.
